// File: rtl/mrc_cmd_sequencer_if.sv
// Bundles the command, response and MRC-side signals of the command sequencer.
// The sequencer uses the slave modport; the environment driving it uses master.
interface mrc_cmd_sequencer_if #(
    parameter int WORD_LENGTH = 16
) ();

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_op;
    logic [WORD_LENGTH-1:0]     cmd_a;
    logic [WORD_LENGTH-1:0]     cmd_b;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [2*WORD_LENGTH-1:0]   rsp_result;
    logic [1:0]                 rsp_status;

    logic                       mrc_start;
    logic                       mrc_load;
    logic [1:0]                 mrc_op;
    logic [WORD_LENGTH-1:0]     mrc_data;
    logic                       mrc_x;
    logic                       mrc_y;
    logic                       mrc_ready;
    logic                       mrc_error;
    logic [2*WORD_LENGTH-1:0]   mrc_result;

    logic                       busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  rsp_ready,
        input  mrc_x, mrc_y, mrc_ready, mrc_error, mrc_result,
        output cmd_ready,
        output rsp_valid, rsp_result, rsp_status,
        output mrc_start, mrc_load, mrc_op, mrc_data,
        output busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output rsp_ready,
        output mrc_x, mrc_y, mrc_ready, mrc_error, mrc_result,
        input  cmd_ready,
        input  rsp_valid, rsp_result, rsp_status,
        input  mrc_start, mrc_load, mrc_op, mrc_data,
        input  busy
    );

endinterface

// File: rtl/mrc_cmd_sequencer.sv
// Sequences multiply/divide/square-root commands onto an MRC arithmetic unit:
// start strobe, operand loads, acknowledge waits with timeout, one response per command.
module mrc_cmd_sequencer #(
    parameter int WORD_LENGTH = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    mrc_cmd_sequencer_if.slave    bus
);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_MRC_ERR = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        LOAD_A    = 3'd2,
        WAIT_A    = 3'd3,
        LOAD_B    = 3'd4,
        WAIT_B    = 3'd5,
        WAIT_DONE = 3'd6,
        RESP      = 3'd7
    } state_t;

    // Square root needs only operand A; multiply and divide also load B.
    function automatic logic needs_b(input logic [1:0] op);
        needs_b = (op == OP_MUL) || (op == OP_DIV);
    endfunction

    state_t                     state_q, state_d;
    logic [1:0]                 op_q, op_d;
    logic [WORD_LENGTH-1:0]     a_q, a_d;
    logic [WORD_LENGTH-1:0]     b_q, b_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic                       cmd_ready_q, cmd_ready_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [2*WORD_LENGTH-1:0]   rsp_result_q, rsp_result_d;
    logic [1:0]                 rsp_status_q, rsp_status_d;
    logic                       mrc_start_q, mrc_start_d;
    logic                       mrc_load_q, mrc_load_d;
    logic [1:0]                 mrc_op_q, mrc_op_d;
    logic [WORD_LENGTH-1:0]     mrc_data_q, mrc_data_d;
    logic                       busy_q, busy_d;

    // Next-state, operand latch, timeout counter and response capture.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        rsp_result_d = rsp_result_q;
        rsp_status_d = rsp_status_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d = bus.cmd_op;
                    a_d  = bus.cmd_a;
                    b_d  = bus.cmd_b;
                    if (bus.cmd_op == OP_ILL) begin
                        state_d      = RESP;
                        rsp_result_d = '0;
                        rsp_status_d = ST_ILLEGAL;
                    end else begin
                        state_d = START;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = LOAD_A;
            end
            LOAD_A: begin
                state_d = WAIT_A;
                cnt_d   = '0;
            end
            WAIT_A: begin
                if (bus.mrc_x) begin
                    state_d = needs_b(op_q) ? LOAD_B : WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = RESP;
                    rsp_result_d = '0;
                    rsp_status_d = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD_B: begin
                state_d = WAIT_B;
                cnt_d   = '0;
            end
            WAIT_B: begin
                if (bus.mrc_y) begin
                    state_d = WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = RESP;
                    rsp_result_d = '0;
                    rsp_status_d = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.mrc_ready) begin
                    state_d      = RESP;
                    rsp_result_d = bus.mrc_result;
                    rsp_status_d = bus.mrc_error ? ST_MRC_ERR : ST_OK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = RESP;
                    rsp_result_d = '0;
                    rsp_status_d = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop aligned with its state.
    always_comb begin
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        mrc_start_d = 1'b0;
        mrc_load_d  = 1'b0;
        mrc_op_d    = 2'b00;
        mrc_data_d  = '0;
        busy_d      = 1'b1;

        case (state_d)
            IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            START: begin
                mrc_start_d = 1'b1;
                mrc_op_d    = op_d;
            end
            LOAD_A: begin
                mrc_load_d = 1'b1;
                mrc_op_d   = op_d;
                mrc_data_d = a_d;
            end
            WAIT_A: begin
                mrc_op_d   = op_d;
                mrc_data_d = a_d;
            end
            LOAD_B: begin
                mrc_load_d = 1'b1;
                mrc_op_d   = op_d;
                mrc_data_d = b_d;
            end
            WAIT_B: begin
                mrc_op_d   = op_d;
                mrc_data_d = b_d;
            end
            WAIT_DONE: begin
                mrc_op_d = op_d;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
            end
            default: begin
                busy_d = 1'b1;
            end
        endcase
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_status_q <= 2'b00;
            mrc_start_q  <= 1'b0;
            mrc_load_q   <= 1'b0;
            mrc_op_q     <= 2'b00;
            mrc_data_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_status_q <= rsp_status_d;
            mrc_start_q  <= mrc_start_d;
            mrc_load_q   <= mrc_load_d;
            mrc_op_q     <= mrc_op_d;
            mrc_data_q   <= mrc_data_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.mrc_start  = mrc_start_q;
    assign bus.mrc_load   = mrc_load_q;
    assign bus.mrc_op     = mrc_op_q;
    assign bus.mrc_data   = mrc_data_q;
    assign bus.busy       = busy_q;

endmodule
